// File: rtl/bcminer_pkg.sv
// Shared definitions for the miner back-end blocks.
//
// Contents:
//   NONCE_W          width of a nonce
//   nonce_t          nonce word type
//   collect_state_t  result-collector FSM encoding
//   ST_*             the same encodings as plain logic [1:0] constants, for
//                    blocks that keep their state in a plain logic register
package bcminer_pkg;

    localparam int NONCE_W = 32;

    typedef logic [NONCE_W-1:0] nonce_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collect_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/nonce_collector_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush.
//
// The read and write pointers carry one bit beyond the address. The low
// LOGDEPTH bits address storage and wrap modulo the depth. The extra bit
// tells a full FIFO apart from an empty one, and occupancy is always the
// pointer difference, so it cannot drift.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      empties the FIFO this cycle (wins over push and pop)
//   push, din  write request and data; accepted when not full or popping
//   pop        read request; accepted when not empty
//   dout       head entry, 0 when empty
//   count      occupancy 0..2**LOGDEPTH
//   full       count == 2**LOGDEPTH
//   empty      count == 0
module sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int LOGDEPTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    din,
    output logic [WIDTH-1:0]    dout,
    output logic [LOGDEPTH:0]   count,
    output logic                full,
    output logic                empty
);

    localparam int DEPTH = 1 << LOGDEPTH;
    localparam logic [LOGDEPTH:0] PTR_ONE = 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [LOGDEPTH:0] wr_ptr;
    logic [LOGDEPTH:0] rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[LOGDEPTH] != rd_ptr[LOGDEPTH]) &&
                     (wr_ptr[LOGDEPTH-1:0] == rd_ptr[LOGDEPTH-1:0]);
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr[LOGDEPTH-1:0]];

    // Pointer update. Reset and flush both return the FIFO to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage has no reset. Slots past the pointers are never read.
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !flush) begin
            mem[wr_ptr[LOGDEPTH-1:0]] <= din;
        end
    end

endmodule

// File: rtl/nonce_collector.sv
// nonce_collector: captures the nonces of winning hash results into a FIFO
// for the host. It counts the results of the current block and flags block
// completion. A sticky flag records any winning nonce dropped because the
// FIFO was full.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   blockStart    new block: flush FIFO, clear flags and counter, collect
//   resultValid   a hash result is present this cycle
//   success       that result meets difficulty
//   nonceIn       nonce of that result
//   rdValid       FIFO not empty
//   rdReady       host pops the head when rdValid && rdReady
//   rdNonce       FIFO head (0 when empty)
//   count         FIFO occupancy
//   overflow      sticky: a winning nonce was dropped this block
//   blockDone     all 2**COUNTBITS results of the block have been seen
module nonce_collector
    import bcminer_pkg::*;
#(
    parameter int COUNTBITS = 6,
    parameter int LOGDEPTH  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                blockStart,
    input  logic                resultValid,
    input  logic                success,
    input  logic [NONCE_W-1:0]  nonceIn,
    output logic                rdValid,
    input  logic                rdReady,
    output logic [NONCE_W-1:0]  rdNonce,
    output logic [LOGDEPTH:0]   count,
    output logic                overflow,
    output logic                blockDone
);

    localparam logic [COUNTBITS-1:0] CNT_ONE = 1;

    logic [1:0]           state;
    logic [COUNTBITS-1:0] result_cnt;
    logic                 push_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;

    // Only winning results seen while collecting are stored. A push in the
    // same cycle as blockStart is discarded because the flush wins.
    assign push_req = resultValid && success && (state == ST_COLLECT) && !blockStart;

    // A full FIFO loses the push unless the host pops in the same cycle.
    // A full FIFO is never empty, so rdReady alone means a real pop here.
    assign drop = push_req && fifo_full && !rdReady;

    assign rdValid   = !fifo_empty;
    assign blockDone = (state == ST_DONE);

    sync_fifo #(
        .WIDTH    (NONCE_W),
        .LOGDEPTH (LOGDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (blockStart),
        .push  (push_req),
        .pop   (rdReady),
        .din   (nonceIn),
        .dout  (rdNonce),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Block FSM, result counter and sticky overflow. blockStart restarts
    // collection from any state. In COLLECT every valid result is counted.
    // The last result of the block moves the FSM to DONE, and the counter
    // wraps back to zero on that same result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            result_cnt <= '0;
            overflow   <= 1'b0;
        end else if (blockStart) begin
            state      <= ST_COLLECT;
            result_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            case (state)
                ST_COLLECT: begin
                    if (resultValid) begin
                        result_cnt <= result_cnt + CNT_ONE;
                        if (result_cnt == '1) state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_collector.sv
// Directed testbench for nonce_collector. Two instances share one set of
// inputs: dut uses the default parameters, and dut_s uses COUNTBITS=2 so
// that block completion takes only four results.
module tb_nonce_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        blockStart;
    logic        resultValid;
    logic        success;
    logic [31:0] nonceIn;
    logic        rdReady;

    logic        rdValid, overflow, blockDone;
    logic [31:0] rdNonce;
    logic [3:0]  count;
    logic        rdValid_s, overflow_s, blockDone_s;
    logic [31:0] rdNonce_s;
    logic [3:0]  count_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nonce_collector #(.COUNTBITS(6), .LOGDEPTH(3)) dut (
        .clk(clk), .rst(rst), .blockStart(blockStart), .resultValid(resultValid),
        .success(success), .nonceIn(nonceIn), .rdValid(rdValid), .rdReady(rdReady),
        .rdNonce(rdNonce), .count(count), .overflow(overflow), .blockDone(blockDone)
    );

    nonce_collector #(.COUNTBITS(2), .LOGDEPTH(3)) dut_s (
        .clk(clk), .rst(rst), .blockStart(blockStart), .resultValid(resultValid),
        .success(success), .nonceIn(nonceIn), .rdValid(rdValid_s), .rdReady(rdReady),
        .rdNonce(rdNonce_s), .count(count_s), .overflow(overflow_s), .blockDone(blockDone_s)
    );

    // One clock edge. Outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        blockStart = 0; resultValid = 0; success = 0; nonceIn = 0; rdReady = 0;
    endtask

    task automatic start_block();
        idle_inputs();
        blockStart = 1;
        tick();
        blockStart = 0;
    endtask

    task automatic win(input logic [31:0] n);
        resultValid = 1; success = 1; nonceIn = n;
        tick();
        resultValid = 0; success = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdValid got=%0b exp=0", rdValid); end
        checks++; if (rdNonce !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdNonce got=%h exp=0", rdNonce); end
        checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (blockDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_blockDone got=%0b exp=0", blockDone); end
        // Results are ignored while the FSM is idle.
        win(32'hDEAD);
        checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL idle_ignore got=%0d exp=0", count); end
    endtask

    task automatic test_basic();
        logic [31:0] exp [3];
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
        start_block();
        win(32'h11);
        checks++; if (rdValid !== 1'b1 || rdNonce !== 32'h11) begin failures++; $display("[TB] FAIL basic_latency got=%0b/%h exp=1/11", rdValid, rdNonce); end
        win(32'h22);
        win(32'h33);
        checks++; if (count !== 4'd3) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=3", count); end
        checks++; if (rdNonce !== 32'h11) begin failures++; $display("[TB] FAIL basic_head got=%h exp=11", rdNonce); end
        rdReady = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rdValid !== 1'b1 || rdNonce !== exp[i]) begin failures++; $display("[TB] FAIL basic_drain%0d got=%0b/%h exp=1/%h", i, rdValid, rdNonce, exp[i]); end
            tick();
        end
        rdReady = 0;
        checks++; if (count !== 4'd0 || rdValid !== 1'b0 || rdNonce !== 32'h0) begin failures++; $display("[TB] FAIL basic_empty got=%0d/%0b/%h exp=0/0/0", count, rdValid, rdNonce); end
    endtask

    task automatic test_block_done();
        start_block();
        for (int i = 0; i < 4; i++) begin
            resultValid = 1; success = (i == 1); nonceIn = (i == 1) ? 32'hAB : 32'h100 + i;
            tick();
            if (i == 2) begin
                checks++; if (blockDone_s !== 1'b0) begin failures++; $display("[TB] FAIL done_early got=%0b exp=0", blockDone_s); end
            end
        end
        idle_inputs();
        checks++; if (blockDone_s !== 1'b1) begin failures++; $display("[TB] FAIL done_set got=%0b exp=1", blockDone_s); end
        checks++; if (count_s !== 4'd1 || rdNonce_s !== 32'hAB) begin failures++; $display("[TB] FAIL done_fifo got=%0d/%h exp=1/ab", count_s, rdNonce_s); end
        win(32'hCD);
        checks++; if (count_s !== 4'd1) begin failures++; $display("[TB] FAIL done_ignore got=%0d exp=1", count_s); end
        // A new block leaves DONE and empties the FIFO.
        start_block();
        checks++; if (blockDone_s !== 1'b0 || count_s !== 4'd0) begin failures++; $display("[TB] FAIL done_restart got=%0b/%0d exp=0/0", blockDone_s, count_s); end
    endtask

    task automatic test_full_block();
        start_block();
        for (int i = 0; i < 64; i++) begin
            resultValid = 1; success = 0; nonceIn = i;
            tick();
            if (i == 62) begin
                checks++; if (blockDone !== 1'b0) begin failures++; $display("[TB] FAIL block64_early got=%0b exp=0", blockDone); end
            end
        end
        idle_inputs();
        checks++; if (blockDone !== 1'b1 || count !== 4'd0) begin failures++; $display("[TB] FAIL block64_done got=%0b/%0d exp=1/0", blockDone, count); end
    endtask

    task automatic test_overflow();
        start_block();
        for (int i = 0; i < 8; i++) win(32'hA0 + i);
        checks++; if (count !== 4'd8 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_full got=%0d/%0b exp=8/0", count, overflow); end
        win(32'hA8);
        checks++; if (count !== 4'd8 || overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_drop got=%0d/%0b exp=8/1", count, overflow); end
        checks++; if (rdNonce !== 32'hA0) begin failures++; $display("[TB] FAIL ovf_head got=%h exp=a0", rdNonce); end
        tick(); tick();
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%0b exp=1", overflow); end
        start_block();
        checks++; if (overflow !== 1'b0 || count !== 4'd0) begin failures++; $display("[TB] FAIL ovf_clear got=%0b/%0d exp=0/0", overflow, count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [8];
        start_block();
        for (int i = 0; i < 8; i++) win(32'hB0 + i);
        // Push into a full FIFO while popping: both happen.
        rdReady = 1;
        win(32'h99);
        checks++; if (count !== 4'd8 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL b2b_count got=%0d/%0b exp=8/0", count, overflow); end
        for (int i = 0; i < 7; i++) exp[i] = 32'hB1 + i;
        exp[7] = 32'h99;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rdNonce !== exp[i]) begin failures++; $display("[TB] FAIL b2b_drain%0d got=%h exp=%h", i, rdNonce, exp[i]); end
            tick();
        end
        rdReady = 0;
        checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL b2b_empty got=%0d exp=0", count); end
    endtask

    task automatic test_flush_collision();
        start_block();
        // An empty FIFO with rdReady high still takes the push. Nothing is popped.
        rdReady = 1;
        win(32'h77);
        checks++; if (count !== 4'd1 || rdNonce !== 32'h77) begin failures++; $display("[TB] FAIL empty_pushpop got=%0d/%h exp=1/77", count, rdNonce); end
        tick();
        rdReady = 0;
        checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL empty_pop got=%0d exp=0", count); end
        win(32'h41);
        win(32'h42);
        blockStart = 1; resultValid = 1; success = 1; nonceIn = 32'h55; rdReady = 1;
        #1;
        checks++; if (rdNonce !== 32'h41) begin failures++; $display("[TB] FAIL flush_handshake got=%h exp=41", rdNonce); end
        tick();
        idle_inputs();
        checks++; if (count !== 4'd0 || rdValid !== 1'b0 || overflow !== 1'b0 || blockDone !== 1'b0) begin failures++; $display("[TB] FAIL flush_state got=%0d/%0b/%0b/%0b exp=0/0/0/0", count, rdValid, overflow, blockDone); end
        win(32'h66);
        checks++; if (count !== 4'd1 || rdNonce !== 32'h66) begin failures++; $display("[TB] FAIL flush_collect got=%0d/%h exp=1/66", count, rdNonce); end
    endtask

    task automatic test_reset_mid();
        start_block();
        for (int i = 0; i < 9; i++) win(32'hC0 + i);
        rdReady = 1;
        tick(); tick(); tick();
        rdReady = 0;
        checks++; if (count !== 4'd5 || overflow !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre got=%0d/%0b exp=5/1", count, overflow); end
        rst = 1; resultValid = 1; success = 1; nonceIn = 32'hEE; rdReady = 1;
        tick();
        rst = 0;
        checks++; if (count !== 4'd0 || rdValid !== 1'b0 || rdNonce !== 32'h0 || overflow !== 1'b0 || blockDone !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_out got=%0d/%0b/%h/%0b/%0b exp=0/0/0/0/0", count, rdValid, rdNonce, overflow, blockDone); end
        rdReady = 0;
        tick(); tick();
        idle_inputs();
        checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_idle got=%0d exp=0", count); end
        start_block();
        win(32'hF1);
        checks++; if (count !== 4'd1 || rdNonce !== 32'hF1) begin failures++; $display("[TB] FAIL rstmid_resume got=%0d/%h exp=1/f1", count, rdNonce); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_basic();
        test_block_done();
        test_full_block();
        test_overflow();
        test_back_to_back();
        test_flush_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
